// File: rtl/centroid_ctrl.sv
// Centroid datapath sequencer: column handshake, zero-pad flush, corner tag pipeline.
// Optional reject counter output enabled by CENTROID_CTRL_STATS_EN.
module centroid_ctrl #(
   parameter int WIN = 37,
   parameter int LAT = 43,
   parameter int XW  = 11,
   parameter int YW  = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          col_valid,
   output logic          col_ready,
   input  logic          col_sof,
   input  logic          col_sol,
   input  logic          col_eol,
   input  logic          col_corner,
   output logic          cen_ena,
   output logic          cen_pad,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y,
   output logic          busy
`ifdef CENTROID_CTRL_STATS_EN
   ,
   output logic [15:0]   reject_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   localparam int FW = $clog2(LAT + 1);
   localparam logic [XW-1:0] EDGE = XW'(WIN - 1);
   localparam logic [XW-1:0] HALF = XW'((WIN - 1) / 2);
   localparam logic [XW-1:0] XMAX = '1;

   state_t state, state_nxt;
   logic [FW-1:0] fcnt;
   logic [XW-1:0] x_cnt, x_cur;
   logic [YW-1:0] y_cnt, y_cur;
   logic hold, fire, flush_adv, flush_done, take;

   logic [LAT-1:0] tv;
   logic [XW-1:0]  tx [LAT];
   logic [YW-1:0]  ty [LAT];

   assign out_valid  = tv[LAT-1];
   assign out_x      = tx[LAT-1];
   assign out_y      = ty[LAT-1];

   assign hold       = out_valid & ~out_ready;
   assign col_ready  = (state != FLUSH) & ~hold;
   assign fire       = col_valid & col_ready;
   assign flush_adv  = (state == FLUSH) & ~hold;
   assign cen_ena    = fire | flush_adv;
   assign cen_pad    = (state == FLUSH);
   assign flush_done = flush_adv & (fcnt == FW'(LAT - 1));

   assign x_cur = col_sol ? '0 : x_cnt;
   assign y_cur = col_sof ? '0 : y_cnt;
   // only windows fully inside the row produce a tag
   assign take  = fire & col_corner & (x_cur >= EDGE);
   assign busy  = (state != IDLE) | (|tv);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fire) state_nxt = col_eol ? FLUSH : RUN;
         RUN:     if (fire & col_eol) state_nxt = FLUSH;
         FLUSH:   if (flush_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         fcnt  <= '0;
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (fire)
            x_cnt <= (x_cur == XMAX) ? XMAX : x_cur + 1'b1;
         if (fire & col_sof)
            y_cnt <= '0;
         else if (flush_done)
            y_cnt <= y_cnt + 1'b1;
         if (state != FLUSH)
            fcnt <= '0;
         else if (flush_adv)
            fcnt <= fcnt + 1'b1;
      end
   end

   // tags advance in lock-step with the datapath enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tv <= '0;
         for (int i = 0; i < LAT; i++) begin
            tx[i] <= '0;
            ty[i] <= '0;
         end
      end else if (cen_ena) begin
         tv    <= {tv[LAT-2:0], take};
         tx[0] <= take ? x_cur - HALF : '0;
         ty[0] <= take ? y_cur : '0;
         for (int i = 1; i < LAT; i++) begin
            tx[i] <= tx[i-1];
            ty[i] <= ty[i-1];
         end
      end
   end

`ifdef CENTROID_CTRL_STATS_EN
   logic rej;
   assign rej = fire & col_corner & (x_cur < EDGE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         reject_cnt <= '0;
      else if (fire & col_sof)
         reject_cnt <= {15'd0, rej};
      else if (rej & ~&reject_cnt)
         reject_cnt <= reject_cnt + 1'b1;
   end
`endif

endmodule
